// File: rtl/rrb_channel_queues_pkg.sv
// Shared constants and helpers for the weighted round-robin arbitration path.
package rrb_channel_queues_pkg;
  localparam int CHANNELS = 8;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int MAX_CH   = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Widest grant the helper accepts; narrower vectors are zero-extended by the caller.
  function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/rrb_channel_queues_if.sv
// Channel-side writes, arbiter grant/request and the single popped output stream.
interface rrb_channel_queues_if
  import rrb_channel_queues_pkg::*;
#(
  parameter int channels   = CHANNELS,
  parameter int data_width = WIDTH
);
  logic [channels-1:0]            in_valid;
  logic [channels*data_width-1:0] in_data;
  logic [channels-1:0]            in_ready;
  logic [channels-1:0]            request;
  logic [channels-1:0]            grant;
  logic                           out_valid;
  logic [data_width-1:0]          out_data;
  logic [clog2(channels)-1:0]     out_channel;
  logic                           grant_err;

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, request, out_valid, out_data, out_channel, grant_err
  );

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, request, out_valid, out_data, out_channel, grant_err
  );
endinterface

// File: rtl/rrb_chan_fifo.sv
// Single-channel synchronous FIFO; depth must be a power of two so pointers wrap naturally.
module rrb_chan_fifo
  import rrb_channel_queues_pkg::*;
#(
  parameter int data_width = WIDTH,
  parameter int depth      = DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [data_width-1:0]       wr_data,
  input  logic                        pop,
  output logic [data_width-1:0]       rd_data,
  output logic [clog2(depth+1)-1:0]   count,
  output logic                        full,
  output logic                        empty
);
  localparam int aw   = clog2(depth);
  localparam int cntw = clog2(depth + 1);

  logic [data_width-1:0] mem [depth];
  logic [aw-1:0]         wr_ptr;
  logic [aw-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == cntw'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset: cleared pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rrb_channel_queues.sv
// Per-channel queue bank feeding the arbiter; pops the one-hot granted channel onto a registered stream.
module rrb_channel_queues
  import rrb_channel_queues_pkg::*;
#(
  parameter int channels   = CHANNELS,
  parameter int data_width = WIDTH,
  parameter int depth      = DEPTH
) (
  input logic                 clk,
  input logic                 reset,
  rrb_channel_queues_if.slave bus
);
  localparam int cw   = clog2(channels);
  localparam int cntw = clog2(depth + 1);

  logic [channels-1:0]   full;
  logic [channels-1:0]   empty;
  logic [channels-1:0]   push;
  logic [channels-1:0]   pop;
  logic [data_width-1:0] rd_data [channels];
  logic [cntw-1:0]       count   [channels];
  logic                  grant_onehot;
  logic                  grant_multi;
  logic [cw-1:0]         sel_idx;
  logic [data_width-1:0] sel_data;

  assign grant_onehot = is_onehot(MAX_CH'(bus.grant));
  assign grant_multi  = (bus.grant != '0) && !grant_onehot;

  // Flags come from registered counts only, so a same-cycle pop never opens space.
  assign bus.in_ready = ~full  & {channels{~reset}};
  assign bus.request  = ~empty & {channels{~reset}};

  for (genvar gi = 0; gi < channels; gi++) begin : g_ch
    assign push[gi] = bus.in_valid[gi] & ~full[gi];
    assign pop[gi]  = bus.grant[gi] & grant_onehot & (count[gi] != '0);

    rrb_chan_fifo #(
      .data_width (data_width),
      .depth      (depth)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push[gi]),
      .wr_data (bus.in_data[gi*data_width +: data_width]),
      .pop     (pop[gi]),
      .rd_data (rd_data[gi]),
      .count   (count[gi]),
      .full    (full[gi]),
      .empty   (empty[gi])
    );
  end

  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < channels; i++) begin
      if (pop[i]) begin
        sel_idx  = cw'(i);
        sel_data = rd_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_channel <= '0;
      bus.grant_err   <= 1'b0;
    end else begin
      bus.out_valid <= |pop;
      if (|pop) begin
        bus.out_data    <= sel_data;
        bus.out_channel <= sel_idx;
      end
      if (grant_multi) bus.grant_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rrb_channel_queues.sv
// Scoreboard bench for rrb_channel_queues: a queue-based channel model predicts pops and output words.
module tb_rrb_channel_queues;
  import rrb_channel_queues_pkg::*;

  localparam int CH = 8;
  localparam int W  = 32;
  localparam int D  = 4;

  typedef struct packed {
    logic [2:0]   ch;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rrb_channel_queues_if #(.channels(CH), .data_width(W)) bus();

  rrb_channel_queues #(.channels(CH), .data_width(W), .depth(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [W-1:0] mq [CH][$];
  logic        model_err;
  exp_t        e;

  // Advance one clock and update the reference model from the inputs seen at the edge.
  task automatic tick();
    logic [CH-1:0] acc;
    logic [CH-1:0] pp;
    logic          oh;
    exp_t          x;
    acc = '0;
    pp  = '0;
    oh  = (bus.grant != '0) && ((bus.grant & (bus.grant - 1'b1)) == '0);
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        acc[c] = bus.in_valid[c] && (mq[c].size() < D);
        pp[c]  = oh && bus.grant[c] && (mq[c].size() > 0);
        if (pp[c]) begin
          x.ch   = 3'(c);
          x.data = mq[c][0];
          exp_q.push_back(x);
        end
      end
      if (bus.grant != '0 && !oh) model_err = 1'b1;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      exp_q.delete();
      model_err = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (pp[c])  void'(mq[c].pop_front());
        if (acc[c]) mq[c].push_back(bus.in_data[c*W +: W]);
      end
    end
  endtask

  task automatic set_word(input int c, input logic [W-1:0] d);
    bus.in_valid[c]        = 1'b1;
    bus.in_data[c*W +: W]  = d;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.grant    = '0;
    #1;
    checks++;
    if (bus.in_ready !== 8'h00 || bus.request !== 8'h00) begin
      failures++;
      $display("FAIL reset_forced_flags in_ready=%h request=%h required 00/00", bus.in_ready, bus.request);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 8'hFF) begin
      failures++;
      $display("FAIL reset_in_ready got=%h required=ff", bus.in_ready);
    end
    checks++;
    if (bus.request !== 8'h00 || bus.out_valid !== 1'b0 || bus.grant_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle request=%h out_valid=%b grant_err=%b required 00/0/0",
               bus.request, bus.out_valid, bus.grant_err);
    end
  endtask

  task automatic test_fifo_order();
    for (int k = 0; k < 3; k++) begin
      set_word(2, W'(32'hA0 + k));
      tick();
      checks++;
      if (bus.request[2] !== 1'b1) begin
        failures++;
        $display("FAIL order_request_rise k=%0d got=%b required=1", k, bus.request[2]);
      end
    end
    bus.in_valid = '0;
    bus.grant    = 8'h04;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_channel !== e.ch) begin
          failures++;
          $display("FAIL order_sb k=%0d got v=%b d=%h ch=%0d required v=1 d=%h ch=%0d",
                   k, bus.out_valid, bus.out_data, bus.out_channel, e.data, e.ch);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL order_idle k=%0d out_valid=%b required=0", k, bus.out_valid);
        end
      end
      if (k < 3) begin
        checks++;
        if (bus.out_data !== W'(32'hA0 + k) || bus.out_channel !== 3'd2) begin
          failures++;
          $display("FAIL order_const k=%0d got d=%h ch=%0d required d=%h ch=2",
                   k, bus.out_data, bus.out_channel, 32'hA0 + k);
        end
      end
      if (k >= 2) begin
        checks++;
        if (bus.request[2] !== 1'b0) begin
          failures++;
          $display("FAIL order_request_fall k=%0d got=%b required=0", k, bus.request[2]);
        end
      end
    end
    bus.grant = '0;
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) begin
      set_word(0, W'(32'hB0 + k));
      tick();
      checks++;
      if (bus.in_ready[0] !== (k < 3)) begin
        failures++;
        $display("FAIL full_in_ready k=%0d got=%b required=%b", k, bus.in_ready[0], k < 3);
      end
    end
    set_word(0, 32'hBEEF);
    bus.grant = 8'h01;
    #1;
    checks++;
    if (bus.in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL full_ready_during_pop got=%b required=0", bus.in_ready[0]);
    end
    tick();
    bus.in_valid = '0;
    checks++;
    if (bus.in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL full_ready_after_pop got=%b required=1", bus.in_ready[0]);
    end
    for (int k = 0; k < 5; k++) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_channel !== e.ch) begin
          failures++;
          $display("FAIL full_sb k=%0d got v=%b d=%h ch=%0d required v=1 d=%h ch=%0d",
                   k, bus.out_valid, bus.out_data, bus.out_channel, e.data, e.ch);
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL full_idle k=%0d out_valid=%b required=0", k, bus.out_valid);
        end
      end
      // Head after the overlapped pop: B1..B3 remain, so the drain ends with k=3.
      if (k >= 1 && k <= 3) begin
        checks++;
        if (bus.out_data !== W'(32'hB0 + k)) begin
          failures++;
          $display("FAIL full_drain_const k=%0d got=%h required=%h", k, bus.out_data, 32'hB0 + k);
        end
      end
      if (k < 4) tick();
    end
    bus.grant = '0;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      set_word(5, W'(k));
      bus.grant = '0;
      tick();
      bus.in_valid = '0;
      bus.grant    = 8'h20;
      tick();
      e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== W'(k) || bus.out_channel !== 3'd5 || e.data !== W'(k)) begin
        failures++;
        $display("FAIL wrap k=%0d got v=%b d=%h ch=%0d required v=1 d=%h ch=5",
                 k, bus.out_valid, bus.out_data, bus.out_channel, k);
      end
      checks++;
      if (bus.request[5] !== 1'b0 || bus.in_ready[5] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_flags k=%0d request=%b in_ready=%b required 0/1", k, bus.request[5], bus.in_ready[5]);
      end
    end
    bus.grant = '0;
    tick();
  endtask

  task automatic test_multi_grant();
    set_word(1, 32'hC1);
    set_word(2, 32'hC2);
    tick();
    bus.in_valid = '0;
    bus.grant    = 8'h06;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.grant_err !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL multi_grant out_valid=%b grant_err=%b required 0/1", bus.out_valid, bus.grant_err);
    end
    checks++;
    if (bus.request[2:1] !== 2'b11) begin
      failures++;
      $display("FAIL multi_counts request=%b required=11", bus.request[2:1]);
    end
    for (int k = 0; k < 2; k++) begin
      bus.grant = (k == 0) ? 8'h02 : 8'h04;
      tick();
      e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_channel !== e.ch
          || bus.out_data !== W'(32'hC1 + k)) begin
        failures++;
        $display("FAIL multi_followup k=%0d got v=%b d=%h ch=%0d required d=%h",
                 k, bus.out_valid, bus.out_data, bus.out_channel, 32'hC1 + k);
      end
    end
    bus.grant = '0;
    tick();
    checks++;
    if (bus.grant_err !== model_err || bus.grant_err !== 1'b1) begin
      failures++;
      $display("FAIL multi_sticky grant_err=%b required=1", bus.grant_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.grant_err !== 1'b0) begin
      failures++;
      $display("FAIL multi_reset_clear grant_err=%b required=0", bus.grant_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      set_word(7, W'(32'hD0 + k));
      tick();
    end
    set_word(7, 32'hDD);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = '0;
    #1;
    checks++;
    if (bus.request[7] !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready[7] !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid request=%b out_valid=%b in_ready=%b required 0/0/1",
               bus.request[7], bus.out_valid, bus.in_ready[7]);
    end
    bus.grant = 8'h80;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_grant out_valid=%b required=0", bus.out_valid);
    end
    bus.grant = '0;
  endtask

  initial begin
    model_err = 1'b0;
    test_reset();
    test_fifo_order();
    test_full();
    test_wrap();
    test_multi_grant();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
